ekf_stage_sched: RTL and testbench

- Stage scheduler in front of the EKF-SLAM core (Top).
- Accepts queued stage requests (PRD, NEW, UPD, ASSOC) from the host/testbench and checks each against the landmark count, which this block owns.
- Drives the core's stage_val and l_k for a fixed pulse, waits for completion or timeout, and returns one response per request.
- Replaces hand-timed stage_val pulses with handshaked sequencing.

---
 rtl/ekf_pkg.sv | 46 ++++
 rtl/ekf_stage_sched_if.sv | 30 +++
 rtl/ekf_stage_fifo.sv | 49 ++++
 rtl/ekf_stage_sched.sv | 119 +++++++++++
 tb/tb_ekf_stage_sched.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ekf_pkg.sv
// Shared definitions for the EKF stage scheduler: stage and response codes,
// scheduler state encoding, sizing constants and the request legality rule.
package ekf_pkg;

   localparam int ROW_LEN    = 10;
   localparam int FIFO_DEPTH = 4;
   localparam int PULSE_LEN  = 2;
   localparam int TIMEOUT    = 1023;
   localparam int TO_W       = 12;
   localparam int MAX_LM     = 1000;

   typedef enum logic [2:0] {
      STG_IDLE  = 3'b000,
      STG_PRD   = 3'b001,
      STG_NEW   = 3'b010,
      STG_UPD   = 3'b011,
      STG_ASSOC = 3'b100
   } stage_e;

   typedef enum logic [1:0] {
      ERR_OK      = 2'b00,
      ERR_ILLEGAL = 2'b01,
      ERR_TIMEOUT = 2'b10
   } rsp_err_e;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CHECK = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_RESP  = 3'd4
   } sched_state_e;

   // NEW may only append at the end of the map, and only while there is room.
   function automatic logic stage_legal(input logic [2:0]         stage,
                                        input logic [ROW_LEN-1:0] lk,
                                        input logic [ROW_LEN-1:0] lm);
      case (stage)
         STG_PRD:            return 1'b1;
         STG_NEW:            return (lk == lm) && (lm < ROW_LEN'(MAX_LM));
         STG_UPD, STG_ASSOC: return lk < lm;
         default:            return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ekf_stage_sched_if.sv
// Host request/response, landmark load and core-side signals of the stage scheduler.
interface ekf_stage_sched_if;
   import ekf_pkg::*;

   logic               req_val;
   logic [2:0]         req_stage;
   logic [ROW_LEN-1:0] req_lk;
   logic               req_rdy;
   logic               lm_load;
   logic [ROW_LEN-1:0] lm_init;
   logic [2:0]         stage_val;
   logic [ROW_LEN-1:0] l_k;
   logic [ROW_LEN-1:0] landmark_num;
   logic               core_done;
   logic               rsp_val;
   logic [2:0]         rsp_stage;
   logic [1:0]         rsp_err;
   logic               busy;

   modport master (
      output req_val, req_stage, req_lk, lm_load, lm_init, core_done,
      input  req_rdy, stage_val, l_k, landmark_num, rsp_val, rsp_stage, rsp_err, busy
   );

   modport slave (
      input  req_val, req_stage, req_lk, lm_load, lm_init, core_done,
      output req_rdy, stage_val, l_k, landmark_num, rsp_val, rsp_stage, rsp_err, busy
   );

endinterface

// File: rtl/ekf_stage_fifo.sv
// Request queue: synchronous FIFO, power-of-two depth, pointers wrap naturally.
module ekf_stage_fifo
   import ekf_pkg::*;
#(
   parameter  int WIDTH = 3 + ROW_LEN,
   parameter  int DEPTH = FIFO_DEPTH,
   localparam int AW    = $clog2(DEPTH),
   localparam int CNT_W = AW + 1
) (
   input  logic             clk,
   input  logic             sys_rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/ekf_stage_sched.sv
// Stage scheduler in front of the EKF-SLAM core: queues host requests, checks them
// against the owned landmark count, pulses stage_val, waits for done or timeout.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | pop queue head if any, else accept landmark count load
//   S_CHECK | latch l_k, decide legality of held request
//   S_ISSUE | drive stage_val for PULSE_LEN cycles
//   S_WAIT  | wait for core_done, bounded by TIMEOUT
//   S_RESP  | one-cycle response strobe, bump landmark count on good NEW
module ekf_stage_sched
   import ekf_pkg::*;
(
   input logic                clk,
   input logic                sys_rst,
   ekf_stage_sched_if.slave   bus
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   sched_state_e       state, state_nxt;
   logic [2:0]         hold_stage;
   logic [ROW_LEN-1:0] hold_lk;
   logic [ROW_LEN-1:0] lm;
   logic [ROW_LEN-1:0] lk_q;
   logic [TO_W-1:0]    tmr;
   logic [1:0]         err_q;
   logic               pop;
   logic               legal;
   logic [ROW_LEN+2:0] fifo_rdata;
   logic               fifo_full;
   logic               fifo_empty;
   logic [CNT_W-1:0]   fifo_count;

   ekf_stage_fifo u_fifo (
      .clk     (clk),
      .sys_rst (sys_rst),
      .push    (bus.req_val && bus.req_rdy),
      .pop     (pop),
      .wdata   ({bus.req_stage, bus.req_lk}),
      .rdata   (fifo_rdata),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign legal = stage_legal(hold_stage, hold_lk, lm);

   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) state <= S_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               state_nxt = S_CHECK;
            end
         end
         S_CHECK: state_nxt = legal ? S_ISSUE : S_RESP;
         S_ISSUE: if (tmr == '0) state_nxt = S_WAIT;
         S_WAIT:  if (bus.core_done || tmr == '0) state_nxt = S_RESP;
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // One down-counter serves both the issue pulse and the wait timeout.
   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         hold_stage <= '0;
         hold_lk    <= '0;
         lm         <= '0;
         lk_q       <= '0;
         tmr        <= '0;
         err_q      <= ERR_OK;
      end else begin
         case (state)
            S_IDLE: begin
               if (!fifo_empty)      {hold_stage, hold_lk} <= fifo_rdata;
               else if (bus.lm_load) lm <= bus.lm_init;
            end
            S_CHECK: begin
               lk_q  <= hold_lk;
               tmr   <= TO_W'(PULSE_LEN - 1);
               err_q <= legal ? ERR_OK : ERR_ILLEGAL;
            end
            S_ISSUE: begin
               if (tmr == '0) tmr <= TO_W'(TIMEOUT);
               else           tmr <= tmr - 1'b1;
            end
            S_WAIT: begin
               if (bus.core_done)   err_q <= ERR_OK;
               else if (tmr == '0)  err_q <= ERR_TIMEOUT;
               else                 tmr   <= tmr - 1'b1;
            end
            S_RESP: begin
               if (err_q == ERR_OK && hold_stage == STG_NEW && lm < ROW_LEN'(MAX_LM))
                  lm <= lm + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.req_rdy      = !fifo_full;
   assign bus.stage_val    = (state == S_ISSUE) ? hold_stage : 3'b000;
   assign bus.l_k          = lk_q;
   assign bus.landmark_num = lm;
   assign bus.rsp_val      = (state == S_RESP);
   assign bus.rsp_stage    = (state == S_RESP) ? hold_stage : 3'b000;
   assign bus.rsp_err      = (state == S_RESP) ? err_q : 2'b00;
   assign bus.busy         = (state != S_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_ekf_stage_sched.sv
// Bench for ekf_stage_sched: transaction-age reference model compared every cycle,
// directed scenarios with hand-computed latencies, then randomized traffic.
module tb_ekf_stage_sched;
   import ekf_pkg::*;

   typedef struct {
      int stage;
      int lk;
   } req_t;

   logic clk = 1'b0;
   logic sys_rst = 1'b1;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ekf_stage_sched_if bus ();

   ekf_stage_sched dut (
      .clk     (clk),
      .sys_rst (sys_rst),
      .bus     (bus)
   );

   // reference model state
   req_t mq[$];
   int   m_lm = 0, m_lk = 0;
   bit   j_act = 0, j_legal = 0, j_resp = 0;
   int   j_stage = 0, j_lk = 0, j_age = 0, j_err = 0;

   // observation
   int   sv_cnt = 0, sv_first = -1, rsp_cnt = 0;
   int   last_stage = 0, last_err = 0, last_cyc = 0;
   bit   sv_prev = 0;
   int   rsp_hist[$];
   int   push_cyc = 0;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit legal_ref(input int st, input int lk, input int lm);
      if (st == 1) return 1'b1;
      if (st == 2) return (lk == lm) && (lm < MAX_LM);
      if (st == 3 || st == 4) return lk < lm;
      return 1'b0;
   endfunction

   always @(negedge clk) begin : model
      bit   acc;
      int   exp_sv;
      req_t r;
      if (sys_rst) begin
         mq.delete();
         m_lm = 0; m_lk = 0;
         j_act = 0; j_resp = 0; j_legal = 0; j_stage = 0; j_age = 0; j_err = 0;
      end
      exp_sv = (j_act && !j_resp && j_legal && j_age >= 1 && j_age <= PULSE_LEN) ? j_stage : 0;
      check("req_rdy",      bus.req_rdy,      int'(mq.size() < FIFO_DEPTH));
      check("busy",         bus.busy,         int'(j_act || mq.size() != 0));
      check("landmark_num", bus.landmark_num, m_lm);
      check("l_k",          bus.l_k,          m_lk);
      check("stage_val",    bus.stage_val,    exp_sv);
      check("rsp_val",      bus.rsp_val,      int'(j_resp));
      check("rsp_stage",    bus.rsp_stage,    j_resp ? j_stage : 0);
      check("rsp_err",      bus.rsp_err,      j_resp ? j_err : 0);

      if (bus.stage_val != 3'b000) begin
         sv_cnt++;
         if (!sv_prev) sv_first = cyc;
      end
      sv_prev = (bus.stage_val != 3'b000);
      if (bus.rsp_val) begin
         rsp_cnt++;
         last_stage = bus.rsp_stage;
         last_err   = bus.rsp_err;
         last_cyc   = cyc;
         rsp_hist.push_back(int'(bus.rsp_stage));
      end

      if (!sys_rst) begin
         acc = bus.req_val && (mq.size() < FIFO_DEPTH);
         if (j_resp) begin
            if (j_err == 0 && j_stage == 2 && m_lm < MAX_LM) m_lm++;
            j_act = 0; j_resp = 0;
         end else if (j_act) begin
            if (j_age == 0) begin
               m_lk = j_lk;
               if (!j_legal) begin j_resp = 1; j_err = 1; end
               else j_age = 1;
            end else if (j_age <= PULSE_LEN) j_age++;
            else if (bus.core_done) begin j_resp = 1; j_err = 0; end
            else if (j_age - PULSE_LEN - 1 == TIMEOUT) begin j_resp = 1; j_err = 2; end
            else j_age++;
         end else if (mq.size() != 0) begin
            r = mq.pop_front();
            j_act = 1; j_age = 0; j_stage = r.stage; j_lk = r.lk;
            j_legal = legal_ref(r.stage, r.lk, m_lm);
         end else if (bus.lm_load) begin
            m_lm = int'(bus.lm_init);
         end
         if (acc) begin
            r.stage = int'(bus.req_stage);
            r.lk    = int'(bus.req_lk);
            mq.push_back(r);
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input int st, input int lk);
      bus.req_val   = 1'b1;
      bus.req_stage = 3'(st);
      bus.req_lk    = ROW_LEN'(lk);
      push_cyc      = cyc;
      tick();
      bus.req_val   = 1'b0;
   endtask

   task automatic pulse_done();
      bus.core_done = 1'b1;
      tick();
      bus.core_done = 1'b0;
   endtask

   task automatic wait_rsp(input int n_before, input int budget);
      int k = 0;
      while (rsp_cnt == n_before && k < budget) begin
         tick();
         k++;
      end
      check("wait_rsp_arrived", int'(rsp_cnt > n_before), 1);
   endtask

   task automatic load_lm(input int v);
      bus.lm_load = 1'b1;
      bus.lm_init = ROW_LEN'(v);
      tick();
      bus.lm_load = 1'b0;
      tick();
      check("lm_load_value", bus.landmark_num, v);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit, got cycle %0d expected finish", cyc);
      $fatal(1);
   end

   initial begin
      int n, s, accepted, rdy5, k;
      int st4[5];
      int lm_pick[6];
      st4 = '{3, 4, 1, 3, 4};
      bus.req_val = 0; bus.req_stage = 0; bus.req_lk = 0;
      bus.lm_load = 0; bus.lm_init = 0; bus.core_done = 0;

      tick(3);
      check("rst_stage_val", bus.stage_val, 0);
      check("rst_rsp_val",   bus.rsp_val, 0);
      check("rst_busy",      bus.busy, 0);
      check("rst_lm",        bus.landmark_num, 0);
      check("rst_req_rdy",   bus.req_rdy, 1);
      sys_rst = 1'b0;
      tick(2);

      // PRD with a long core latency
      n = rsp_cnt; s = sv_cnt;
      push(STG_PRD, 0);
      tick(600);
      pulse_done();
      wait_rsp(n, 50);
      check("t1_sv_latency", sv_first - push_cyc, 3);
      check("t1_sv_len",     sv_cnt - s, 2);
      check("t1_rsp_stage",  last_stage, 1);
      check("t1_rsp_err",    last_err, 0);
      tick(2);

      // NEW append, then NEW at a hole
      load_lm(4);
      n = rsp_cnt;
      push(STG_NEW, 4);
      tick(10);
      pulse_done();
      wait_rsp(n, 50);
      check("t2_new_err", last_err, 0);
      check("t2_lm_inc",  bus.landmark_num, 5);
      tick(2);
      n = rsp_cnt; s = sv_cnt;
      push(STG_NEW, 2);
      wait_rsp(n, 20);
      check("t2_bad_new_err", last_err, 1);
      check("t2_bad_latency", last_cyc - push_cyc, 3);
      check("t2_bad_no_sv",   sv_cnt - s, 0);
      check("t2_lm_kept",     bus.landmark_num, 5);
      tick(2);

      // UPD / ASSOC range and bad codes
      load_lm(4);
      n = rsp_cnt;
      push(STG_UPD, 2);
      tick(6);
      pulse_done();
      wait_rsp(n, 50);
      check("t3_upd_err", last_err, 0);
      check("t3_upd_lk",  bus.l_k, 2);
      tick(2);
      n = rsp_cnt;
      push(STG_ASSOC, 4);
      wait_rsp(n, 20);
      check("t3_assoc_err", last_err, 1);
      tick(2);
      n = rsp_cnt;
      push(7, 1);
      wait_rsp(n, 20);
      check("t3_code7_err",   last_err, 1);
      check("t3_code7_stage", last_stage, 7);
      tick(2);

      // capacity boundary
      load_lm(MAX_LM);
      n = rsp_cnt;
      push(STG_NEW, MAX_LM);
      wait_rsp(n, 20);
      check("cap_full_err", last_err, 1);
      tick(2);
      load_lm(MAX_LM - 1);
      n = rsp_cnt;
      push(STG_NEW, MAX_LM - 1);
      tick(6);
      pulse_done();
      wait_rsp(n, 50);
      check("cap_last_err", last_err, 0);
      check("cap_last_lm",  bus.landmark_num, MAX_LM);
      tick(2);

      // queue fill behind a waiting PRD
      load_lm(4);
      push(STG_PRD, 0);
      tick(8);
      accepted = 0; rdy5 = -1;
      for (int i = 0; i < 5; i++) begin
         bus.req_val   = 1'b1;
         bus.req_stage = 3'(st4[i]);
         bus.req_lk    = '0;
         if (bus.req_rdy) accepted++;
         if (i == 4) rdy5 = int'(bus.req_rdy);
         tick();
      end
      bus.req_val = 1'b0;
      check("t4_accepted", accepted, 4);
      check("t4_rdy_full", rdy5, 0);
      n = rsp_cnt; k = 0;
      while (rsp_cnt < n + 5 && k < 200) begin
         pulse_done();
         tick(7);
         k++;
      end
      check("t4_rsp_count", rsp_cnt - n, 5);
      if (rsp_cnt - n == 5) begin
         check("t4_order0", rsp_hist[n], 1);
         for (int i = 0; i < 4; i++) check("t4_order", rsp_hist[n + 1 + i], st4[i]);
      end
      tick(2);

      // timeout
      n = rsp_cnt;
      push(STG_NEW, 4);
      wait_rsp(n, 1100);
      check("t5_err",     last_err, 2);
      check("t5_latency", last_cyc - push_cyc, 1029);
      check("t5_lm_kept", bus.landmark_num, 4);
      n = rsp_cnt;
      pulse_done();
      tick(5);
      check("t5_late_done", rsp_cnt - n, 0);

      // reset mid-WAIT with two queued
      push(STG_PRD, 0);
      tick(8);
      push(STG_UPD, 0);
      push(STG_PRD, 0);
      tick(2);
      check("t6_busy_before", bus.busy, 1);
      @(posedge clk);
      #3;
      sys_rst = 1'b1;
      #1;
      check("t6_sv_rst",   bus.stage_val, 0);
      check("t6_rsp_rst",  bus.rsp_val, 0);
      check("t6_busy_rst", bus.busy, 0);
      check("t6_lm_rst",   bus.landmark_num, 0);
      n = rsp_cnt;
      tick(3);
      sys_rst = 1'b0;
      tick(10);
      pulse_done();
      tick(40);
      check("t6_no_rsp", rsp_cnt - n, 0);

      // randomized traffic
      lm_pick = '{0, 3, 998, 999, 1000, 5};
      for (int c = 0; c < 3000; c++) begin
         int sel, lk;
         bus.req_val = ($urandom_range(0, 3) == 0);
         sel = int'($urandom_range(0, 9));
         bus.req_stage = (sel < 8) ? 3'($urandom_range(1, 4)) : 3'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0:       lk = m_lm;
            1:       lk = (m_lm > 0) ? m_lm - 1 : 0;
            2:       lk = m_lm + 1;
            default: lk = int'($urandom_range(0, 15));
         endcase
         bus.req_lk    = ROW_LEN'(lk);
         bus.core_done = ($urandom_range(0, 39) == 0);
         bus.lm_load   = ($urandom_range(0, 30) == 0);
         bus.lm_init   = ROW_LEN'(lm_pick[$urandom_range(0, 5)]);
         tick();
      end
      bus.req_val = 0; bus.core_done = 0; bus.lm_load = 0;
      tick(5);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
